dac_tx_sequencer: RTL and testbench

- Fabric-side controller for the 12-lane, 8:1 HSSIO DAC transmit interface. Sits between the sample source and the high-speed SelectIO core's data_from_fabric inputs.
- Sequences bring-up: waits for the core reset sequence, waits for bitslice calibration, sends a training pattern, then streams samples.
- During streaming it transposes 8 parallel 12-bit samples per app_clk into 12 serializer lane words plus a strobe word. When the source starves, it substitutes a mid-scale idle code.

---
 rtl/dac_tx_if.sv | 10 +
 rtl/dac_tx_sequencer.sv | 140 ++++++++++++++
 tb/tb_dac_tx_sequencer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dac_tx_if.sv
// Sample-source handshake carrying 8 x 12-bit DAC samples per app_clk
// into dac_tx_sequencer.
interface dac_tx_if;
    logic        s_valid;
    logic        s_ready;
    logic [95:0] s_data;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/dac_tx_sequencer.sv
// HSSIO DAC transmit sequencer: brings the 12-lane 8:1 interface up through reset,
// calibration and training, then transposes sample words into serializer lane words.
module dac_tx_sequencer #(
    parameter int unsigned TRAIN_CYCLES = 256,
    parameter logic [7:0]  TRAIN_PAT    = 8'h55,
    parameter logic [11:0] IDLE_CODE    = 12'h800,
    parameter logic [7:0]  STROBE_PAT   = 8'h81
) (
    input  logic        app_clk,
    input  logic        rst_in,
    input  logic        rst_seq_done,
    input  logic [5:0]  dly_rdy,
    input  logic [5:0]  vtc_rdy,
    input  logic        enable,
    dac_tx_if.slave     src,
    output logic [95:0] lane_data,
    output logic [7:0]  strobe_word,
    output logic [2:0]  state_o,
    output logic [15:0] underflow_cnt
);

    localparam logic [2:0] ST_RESET_WAIT = 3'd0;
    localparam logic [2:0] ST_CAL_WAIT   = 3'd1;
    localparam logic [2:0] ST_TRAIN      = 3'd2;
    localparam logic [2:0] ST_READY      = 3'd3;
    localparam logic [2:0] ST_STREAM     = 3'd4;

    localparam logic [15:0] TRAIN_LAST = 16'(TRAIN_CYCLES - 32'd1);

    // Sample j bit k goes to lane k bit (7-j), so sample 0 is serialized first.
    function automatic logic [95:0] transpose(input logic [95:0] samples);
        logic [95:0] lanes;
        lanes = 96'd0;
        for (int k = 0; k < 12; k++) begin
            for (int j = 0; j < 8; j++) begin
                lanes[8*k + 7 - j] = samples[12*j + k];
            end
        end
        return lanes;
    endfunction

    localparam logic [95:0] IDLE_LANES  = transpose({8{IDLE_CODE}});
    localparam logic [95:0] TRAIN_LANES = {12{TRAIN_PAT}};

    logic [2:0]  state_r;
    logic [2:0]  next_state_s;
    logic [15:0] train_cnt_r;
    logic [95:0] lane_r;
    logic [95:0] lane_next_s;
    logic [7:0]  strobe_r;
    logic [15:0] underflow_r;
    logic        cal_ok_s;
    logic        xfer_s;
    logic        starve_s;

    assign cal_ok_s      = (&dly_rdy) && (&vtc_rdy);
    assign src.s_ready   = (state_r == ST_STREAM) && enable;
    assign xfer_s        = src.s_ready && src.s_valid;
    assign starve_s      = (state_r == ST_STREAM) && !src.s_valid;
    assign lane_data     = lane_r;
    assign strobe_word   = strobe_r;
    assign state_o       = state_r;
    assign underflow_cnt = underflow_r;

    // Next-state: loss of the core reset sequence wins, then loss of calibration.
    always_comb begin
        next_state_s = state_r;
        if (!rst_seq_done) begin
            next_state_s = ST_RESET_WAIT;
        end else begin
            case (state_r)
                ST_RESET_WAIT: next_state_s = ST_CAL_WAIT;
                ST_CAL_WAIT: begin
                    if (cal_ok_s) next_state_s = ST_TRAIN;
                    else          next_state_s = ST_CAL_WAIT;
                end
                ST_TRAIN: begin
                    if (!cal_ok_s)                       next_state_s = ST_CAL_WAIT;
                    else if (train_cnt_r == TRAIN_LAST) next_state_s = ST_READY;
                    else                                 next_state_s = ST_TRAIN;
                end
                ST_READY: begin
                    if (!cal_ok_s)   next_state_s = ST_CAL_WAIT;
                    else if (enable) next_state_s = ST_STREAM;
                    else             next_state_s = ST_READY;
                end
                ST_STREAM: begin
                    if (!cal_ok_s)    next_state_s = ST_CAL_WAIT;
                    else if (!enable) next_state_s = ST_READY;
                    else              next_state_s = ST_STREAM;
                end
                default: next_state_s = ST_RESET_WAIT;
            endcase
        end
    end

    // Lane word selection from the current state and handshake.
    always_comb begin
        lane_next_s = IDLE_LANES;
        if (xfer_s) begin
            lane_next_s = transpose(src.s_data);
        end else if (state_r == ST_TRAIN) begin
            lane_next_s = TRAIN_LANES;
        end else begin
            lane_next_s = IDLE_LANES;
        end
    end

    // State, training counter, registered lane/strobe words and starvation count.
    always_ff @(posedge app_clk) begin
        if (rst_in) begin
            state_r     <= ST_RESET_WAIT;
            train_cnt_r <= 16'd0;
            lane_r      <= IDLE_LANES;
            strobe_r    <= 8'h00;
            underflow_r <= 16'd0;
        end else begin
            state_r <= next_state_s;
            lane_r  <= lane_next_s;
            if ((state_r == ST_CAL_WAIT) && (next_state_s == ST_TRAIN)) begin
                train_cnt_r <= 16'd0;
            end else if (state_r == ST_TRAIN) begin
                train_cnt_r <= train_cnt_r + 16'd1;
            end else begin
                train_cnt_r <= train_cnt_r;
            end
            if ((next_state_s == ST_TRAIN) || (next_state_s == ST_STREAM)) begin
                strobe_r <= STROBE_PAT;
            end else begin
                strobe_r <= 8'h00;
            end
            if (starve_s && (underflow_r != 16'hFFFF)) begin
                underflow_r <= underflow_r + 16'd1;
            end else begin
                underflow_r <= underflow_r;
            end
        end
    end

endmodule

// File: tb/tb_dac_tx_sequencer.sv
// Randomized self-checking bench for dac_tx_sequencer: a cycle-level behavioural
// model predicts every output, plus directed literal checks of bring-up and corner cases.
module tb_dac_tx_sequencer;

    localparam int          TRAIN_CYCLES = 256;
    localparam logic [7:0]  TRAIN_PAT    = 8'h55;
    localparam logic [11:0] IDLE_CODE    = 12'h800;
    localparam logic [7:0]  STROBE_PAT   = 8'h81;

    logic        app_clk;
    logic        rst_in;
    logic        rst_seq_done;
    logic [5:0]  dly_rdy;
    logic [5:0]  vtc_rdy;
    logic        enable;
    logic [95:0] lane_data;
    logic [7:0]  strobe_word;
    logic [2:0]  state_o;
    logic [15:0] underflow_cnt;

    dac_tx_if src_if ();

    dac_tx_sequencer dut (
        .app_clk       (app_clk),
        .rst_in        (rst_in),
        .rst_seq_done  (rst_seq_done),
        .dly_rdy       (dly_rdy),
        .vtc_rdy       (vtc_rdy),
        .enable        (enable),
        .src           (src_if),
        .lane_data     (lane_data),
        .strobe_word   (strobe_word),
        .state_o       (state_o),
        .underflow_cnt (underflow_cnt)
    );

    int checks = 0;
    int errors = 0;

    initial begin
        app_clk = 1'b0;
        forever #5 app_clk = ~app_clk;
    end

    // Lane k is the 8-bit word built from bit k of samples 0..7, sample 0 as MSB.
    function automatic logic [95:0] xp(input logic [95:0] d);
        logic [95:0] r;
        int w;
        r = 96'd0;
        for (int k = 0; k < 12; k++) begin
            w = 0;
            for (int j = 0; j < 8; j++) w = (w << 1) | int'(d[12*j + k]);
            r[8*k +: 8] = w[7:0];
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Behavioural model: 0 reset-wait, 1 cal-wait, 2 train, 3 ready, 4 stream.
    logic [2:0]  m_state;
    logic [95:0] m_lane;
    logic [7:0]  m_strobe;
    logic [15:0] m_uf;
    int          m_tin;
    bit          m_ok = 1'b0;

    initial begin
        logic [2:0] nxt;
        logic       cal;
        forever begin
            @(posedge app_clk);
            if (rst_in) begin
                m_state = 3'd0; m_lane = xp({8{IDLE_CODE}}); m_strobe = 8'h00;
                m_uf = 16'd0; m_tin = 0; m_ok = 1'b1;
            end else if (m_ok) begin
                cal = (dly_rdy == 6'h3F) && (vtc_rdy == 6'h3F);
                if (m_state == 3'd4 && enable && src_if.s_valid) m_lane = xp(src_if.s_data);
                else if (m_state == 3'd2) m_lane = {12{TRAIN_PAT}};
                else m_lane = xp({8{IDLE_CODE}});
                if (m_state == 3'd4 && !src_if.s_valid && m_uf != 16'hFFFF) m_uf = m_uf + 16'd1;
                nxt = m_state;
                if (!rst_seq_done) nxt = 3'd0;
                else if (m_state == 3'd0) nxt = 3'd1;
                else if (!cal) nxt = 3'd1;
                else if (m_state == 3'd1) begin nxt = 3'd2; m_tin = 0; end
                else if (m_state == 3'd2) begin
                    if (m_tin == TRAIN_CYCLES - 1) nxt = 3'd3;
                    else m_tin = m_tin + 1;
                end
                else if (m_state == 3'd3) begin if (enable) nxt = 3'd4; end
                else if (m_state == 3'd4) begin if (!enable) nxt = 3'd3; end
                else nxt = 3'd0;
                m_strobe = (nxt == 3'd2 || nxt == 3'd4) ? STROBE_PAT : 8'h00;
                m_state  = nxt;
            end
        end
    end

    // Every-cycle comparison of the DUT against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge app_clk);
            if (m_ok) begin
                chk("state", 128'(state_o), 128'(m_state));
                chk("outputs", 128'({lane_data, strobe_word, underflow_cnt, src_if.s_ready}),
                    128'({m_lane, m_strobe, m_uf, (m_state == 3'd4) && enable}));
            end
        end
    end

    task automatic step();
        @(posedge app_clk);
        #2;
    endtask

    task automatic wait_state(input logic [2:0] tgt, input int budget, input string nm);
        int n = 0;
        while (state_o !== tgt && n < budget) begin step(); n++; end
        chk(nm, 128'(state_o), 128'(tgt));
    endtask

    task automatic measure_train(input string nm);
        int n = 0;
        wait_state(3'd2, 20, {nm, "_enter"});
        while (state_o === 3'd2 && n < 1000) begin
            step(); n++;
            if (n == 3) begin
                chk({nm, "_lanes"}, 128'(lane_data), 128'({12{8'h55}}));
                chk({nm, "_strobe"}, 128'(strobe_word), 128'(8'h81));
            end
        end
        chk({nm, "_len"}, 128'(n), 128'(256));
        chk({nm, "_ready"}, 128'(state_o), 128'(3'd3));
    endtask

    logic [95:0] pat;

    initial begin
        rst_in = 1'b1; rst_seq_done = 1'b0; dly_rdy = 6'h00; vtc_rdy = 6'h00;
        enable = 1'b0; src_if.s_valid = 1'b0; src_if.s_data = 96'd0;
        for (int j = 0; j < 8; j++) pat[12*j +: 12] = 12'h001 << j;

        // Bring-up
        repeat (4) step();
        chk("rst_state", 128'(state_o), 128'(3'd0));
        chk("rst_outs", 128'({lane_data, strobe_word, underflow_cnt, src_if.s_ready}),
            128'({8'hFF, 88'h0, 8'h00, 16'h0000, 1'b0}));
        rst_in = 1'b0;
        repeat (6) step();
        chk("still_wait", 128'(state_o), 128'(3'd0));
        rst_seq_done = 1'b1;
        repeat (10) step();
        chk("cal_wait", 128'(state_o), 128'(3'd1));
        dly_rdy = 6'h3F; vtc_rdy = 6'h3F; enable = 1'b1;
        src_if.s_valid = 1'b1; src_if.s_data = pat;
        measure_train("train1");

        // Transpose on first accepted word
        step();
        chk("stream_entry", 128'(state_o), 128'(3'd4));
        chk("s_ready_hi", 128'(src_if.s_ready), 128'(1'b1));
        step();
        chk("xpose_lanes", 128'(lane_data),
            128'({8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h04, 8'h08,
                  8'h10, 8'h20, 8'h40, 8'h80}));
        chk("xpose_strobe", 128'(strobe_word), 128'(8'h81));

        // Underflow
        src_if.s_valid = 1'b0;
        repeat (5) step();
        chk("uf_lanes", 128'(lane_data), 128'({8'hFF, 88'h0}));
        chk("uf_cnt5", 128'(underflow_cnt), 128'(16'd5));

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            src_if.s_valid = ($urandom_range(0, 3) != 0);
            src_if.s_data  = {$urandom, $urandom, $urandom};
            enable         = ($urandom_range(0, 15) != 0);
            vtc_rdy        = ($urandom_range(0, 499) == 0) ? (6'h3F ^ (6'h01 << $urandom_range(0, 5))) : 6'h3F;
            rst_seq_done   = ($urandom_range(0, 1499) != 0);
            step();
        end
        vtc_rdy = 6'h3F; rst_seq_done = 1'b1; enable = 1'b1;

        // Enable drop mid-stream
        wait_state(3'd4, 700, "restream1");
        src_if.s_valid = 1'b1; enable = 1'b0;
        #1;
        chk("drop_s_ready", 128'(src_if.s_ready), 128'(1'b0));
        step();
        chk("drop_state", 128'(state_o), 128'(3'd3));
        chk("drop_lanes", 128'({lane_data, strobe_word}), 128'({8'hFF, 88'h0, 8'h00}));

        // Calibration loss and retrain, then reset-sequence loss in TRAIN
        enable = 1'b1;
        wait_state(3'd4, 10, "restream2");
        vtc_rdy = 6'h37;
        step();
        chk("cal_loss", 128'(state_o), 128'(3'd1));
        vtc_rdy = 6'h3F;
        measure_train("train2");
        vtc_rdy = 6'h3E;
        step();
        vtc_rdy = 6'h3F;
        wait_state(3'd2, 10, "train3");
        repeat (7) step();
        rst_seq_done = 1'b0;
        step();
        chk("seq_loss", 128'(state_o), 128'(3'd0));
        rst_seq_done = 1'b1;

        // Saturation
        wait_state(3'd4, 700, "restream3");
        src_if.s_valid = 1'b0;
        repeat (70000) step();
        chk("uf_sat", 128'(underflow_cnt), 128'(16'hFFFF));

        // Reset during an accepted transfer
        src_if.s_valid = 1'b1; src_if.s_data = pat; rst_in = 1'b1;
        #1;
        chk("rst_xfer_ready", 128'(src_if.s_ready), 128'(1'b1));
        step();
        chk("rst2_state", 128'(state_o), 128'(3'd0));
        chk("rst2_outs", 128'({lane_data, strobe_word, underflow_cnt, src_if.s_ready}),
            128'({8'hFF, 88'h0, 8'h00, 16'h0000, 1'b0}));
        rst_in = 1'b0;
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
